// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared widths, state encodings and request types for the MIPS memory responder
package mips_mem_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {REQ_READ, REQ_WRITE} req_t;
endpackage

// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: memory request/response bus between the MIPS datapath and the responder
interface mips_mem_responder_if;
  import mips_mem_pkg::*;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_busy;
  logic              mem_error;
  modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready, mem_busy, mem_error);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready, mem_busy, mem_error);
endinterface

// File: rtl/mips_mem_array.sv
// mips_mem_array: single-port synchronous word RAM with registered read
module mips_mem_array
  import mips_mem_pkg::*;
#(parameter int ADDR_W = 8) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: wait-state memory responder for the multicycle MIPS core.
// Define MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses via mem_error.
module mips_mem_responder
  import mips_mem_pkg::*;
#(parameter int ADDR_W = 8, parameter int WAIT_CYCLES = 2) (
  input logic clk,
  input logic rst,
  mips_mem_responder_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t            state, state_nx;
  req_t              typ, a_typ;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx, a_idx;
  logic [DATA_W-1:0] wd, a_wd, q;
  logic              mis, a_mis, live_mis, req, go_resp;
  assign req = bus.mem_read | bus.mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign live_mis = bus.mem_addr[1:0] != 2'b00;
  assign bus.mem_error = state == RESP && mis;
`else
  assign live_mis = 1'b0;
  assign bus.mem_error = 1'b0;
`endif
  // In IDLE the RAM sees the live request so a zero-wait access can complete on the accepting edge
  always_comb begin
    a_idx = state == IDLE ? bus.mem_addr[ADDR_W+1:2] : idx;
    a_wd = state == IDLE ? bus.mem_wdata : wd;
    a_typ = state == IDLE ? (bus.mem_write ? REQ_WRITE : REQ_READ) : typ;
    a_mis = state == IDLE ? live_mis : mis;
    state_nx = state == IDLE ? (req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == LAST ? RESP : WAIT) : IDLE;
    go_resp = state != RESP && state_nx == RESP;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      typ <= REQ_READ;
      idx <= '0;
      wd <= '0;
      mis <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == IDLE && req) begin
        typ <= a_typ;
        idx <= a_idx;
        wd <= a_wd;
        mis <= a_mis;
      end
    end
  mips_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (go_resp && rst),
    .we    (a_typ == REQ_WRITE && !a_mis),
    .addr  (a_idx),
    .wdata (a_wd),
    .rdata (q)
  );
  assign bus.mem_ready = state == RESP;
  assign bus.mem_busy = state != IDLE;
  assign bus.mem_rdata = (state == RESP && typ == REQ_READ && !mis) ? q : '0;
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: timestamp-based reference model plus directed accesses for mips_mem_responder
module tb_mips_mem_responder;
  localparam int W = 2;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  mips_mem_responder_if bus ();
  mips_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: each accepted access owns the busy window [acc, resp] of cycle indices
  int k = 0;
  int acc = -100;
  int resp_at = -100;
  logic m_wr, m_mis;
  int m_idx;
  logic [31:0] m_wd;
  logic [31:0] mdl [2**AW];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc = -100;
      resp_at = -100;
    end else begin
      k++;
      if (!((k - 1) >= acc && (k - 1) <= resp_at) && (bus.mem_read || bus.mem_write)) begin
        acc = k;
        resp_at = k + W;
        m_wr = bus.mem_write;
        m_idx = int'(bus.mem_addr >> 2) % (2**AW);
        m_wd = bus.mem_wdata;
`ifdef MEM_ALIGN_CHECK_EN
        m_mis = bus.mem_addr[1:0] != 2'b00;
`else
        m_mis = 1'b0;
`endif
      end
      if (k == resp_at && m_wr && !m_mis) mdl[m_idx] = m_wd;
    end
  end

  always @(negedge clk) begin
    if (rst && k > 0) begin
      chk("busy", 32'(bus.mem_busy), 32'(k >= acc && k <= resp_at));
      chk("ready", 32'(bus.mem_ready), 32'(k == resp_at));
      chk("error", 32'(bus.mem_error), 32'(k == resp_at && m_mis));
      chk("rdata", bus.mem_rdata, (k == resp_at && !m_wr && !m_mis) ? mdl[m_idx] : 32'h0);
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got, output int lat, output int bz, output logic err);
    @(posedge clk); #2;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_addr = a; bus.mem_wdata = d;
    lat = 0; bz = 0; got = '0; err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_busy) bz++;
      if (bus.mem_ready) begin
        got = bus.mem_rdata;
        err = bus.mem_error;
        break;
      end
    end
    if (!bus.mem_ready) chk("ready_timeout", 32'(bus.mem_ready), 32'h1);
    @(posedge clk); #2;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  logic [31:0] got;
  int lat, bz, gap;
  logic err;
  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.mem_ready), 32'h0);
    chk("rst_busy", 32'(bus.mem_busy), 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_error", 32'(bus.mem_error), 32'h0);
    #1 rst = 1'b1;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, got, lat, bz, err);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_busy_cycles", 32'(bz), 32'd3);
    chk("wr_rdata_zero", got, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, got, lat, bz, err);
    chk("rd_0x10", got, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'h20, 32'h1234, got, lat, bz, err);
    chk("rdwr_no_data", got, 32'h0);
    access(1'b1, 1'b0, 32'h20, 32'h0, got, lat, bz, err);
    chk("rd_0x20", got, 32'h1234);
    access(1'b0, 1'b1, 32'h0, 32'h11111111, got, lat, bz, err);
    access(1'b0, 1'b1, 32'(4 * 2**AW), 32'hA5A5A5A5, got, lat, bz, err);
    access(1'b1, 1'b0, 32'h0, 32'h0, got, lat, bz, err);
    chk("alias_rd_0x0", got, 32'hA5A5A5A5);
    access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, got, lat, bz, err);
    @(posedge clk); #2;
    bus.mem_write = 1'b1; bus.mem_addr = 32'h30; bus.mem_wdata = 32'h00000BAD;
    @(negedge clk); @(negedge clk);
    chk("pre_abort_busy", 32'(bus.mem_busy), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.mem_busy), 32'h0);
    chk("abort_ready", 32'(bus.mem_ready), 32'h0);
    chk("abort_rdata", bus.mem_rdata, 32'h0);
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    access(1'b1, 1'b0, 32'h30, 32'h0, got, lat, bz, err);
    chk("rd_0x30_after_abort", got, 32'hCAFEF00D);
    @(posedge clk); #2;
    bus.mem_read = 1'b1; bus.mem_addr = 32'h10;
    gap = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gap >= 0) gap++;
      if (bus.mem_ready && gap > 0) break;
      if (bus.mem_ready) gap = 0;
    end
    chk("b2b_gap", 32'(gap), 32'(W + 2));
    @(posedge clk); #2;
    bus.mem_read = 1'b0;
    @(posedge clk); #2;
    bus.mem_write = 1'b1; bus.mem_addr = 32'h50; bus.mem_wdata = 32'h5A5A0001;
    @(posedge clk); #2;
    bus.mem_write = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !bus.mem_ready; i++) begin
      @(negedge clk);
      lat++;
    end
    chk("drop_still_ready", 32'(bus.mem_ready), 32'h1);
    access(1'b1, 1'b0, 32'h50, 32'h0, got, lat, bz, err);
    chk("drop_rd_0x50", got, 32'h5A5A0001);
    access(1'b0, 1'b1, 32'h40, 32'h00000077, got, lat, bz, err);
    access(1'b0, 1'b1, 32'h42, 32'h00000099, got, lat, bz, err);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misaligned_error", 32'(err), 32'h1);
    access(1'b1, 1'b0, 32'h40, 32'h0, got, lat, bz, err);
    chk("misaligned_no_write", got, 32'h00000077);
`else
    chk("unaligned_no_error", 32'(err), 32'h0);
    access(1'b1, 1'b0, 32'h40, 32'h0, got, lat, bz, err);
    chk("unaligned_write", got, 32'h00000099);
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
